// File: rtl/anita4_scaler_pkg.sv
// ANITA4 scaler sequencer shared types.
// State encoding and trigger-map channel indices.
package anita4_scaler_pkg;

  localparam int NCH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Bit order of scaler_i / mask_i
  localparam int TOP_LCP0 = 0;
  localparam int TOP_LCP1 = 1;
  localparam int TOP_RCP0 = 2;
  localparam int TOP_RCP1 = 3;
  localparam int MID_LCP0 = 4;
  localparam int MID_LCP1 = 5;
  localparam int MID_RCP0 = 6;
  localparam int MID_RCP1 = 7;
  localparam int BOT_LCP0 = 8;
  localparam int BOT_LCP1 = 9;
  localparam int BOT_RCP0 = 10;
  localparam int BOT_RCP1 = 11;

endpackage

// File: rtl/anita4_scaler_sequencer_if.sv
// Hold-bank read port and readout handshake.
// Master is the register interface, slave the sequencer.
interface anita4_scaler_sequencer_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 rd_en_i;
  logic [3:0]           rd_addr_i;
  logic [CNT_WIDTH-1:0] rd_data_o;
  logic                 rd_valid_o;
  logic                 ready_o;
  logic                 missed_o;
  logic                 ack_i;

  modport master (
    output rd_en_i, rd_addr_i, ack_i,
    input  rd_data_o, rd_valid_o, ready_o, missed_o
  );

  modport slave (
    input  rd_en_i, rd_addr_i, ack_i,
    output rd_data_o, rd_valid_o, ready_o, missed_o
  );
endinterface

// File: rtl/scaler_edge_counter.sv
// One scaler channel: rising-edge detect plus saturating counter.
// clr zeroes the count, load restarts it from this cycle's edge.
module scaler_edge_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_i,
  input  logic                 mask_i,
  input  logic                 clr_i,
  input  logic                 load_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic                 prev_q, prev_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hit;

  always_comb begin
    hit    = in_i & ~prev_q & ~mask_i;
    prev_d = in_i;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = {{(CNT_WIDTH-1){1'b0}}, hit};
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // prev resets high so a line already asserted is not an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/anita4_scaler_sequencer.sv
// Gated rate scaler: per-channel counts over a gate period,
// latched into a hold bank with no dead time between gates.
module anita4_scaler_sequencer
  import anita4_scaler_pkg::*;
#(
  parameter int NCH          = NCH_DEFAULT,
  parameter int CNT_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NCH-1:0]          scaler_i,
  input  logic [NCH-1:0]          mask_i,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  output logic                    gate_o,
  anita4_scaler_sequencer_if.slave rd_if
);

  state_t state_q, state_d;

  logic [PERIOD_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_WIDTH-1:0] period_cap;

  logic [CNT_WIDTH-1:0] live   [NCH];
  logic [CNT_WIDTH-1:0] hold_q [NCH];
  logic [CNT_WIDTH-1:0] hold_d [NCH];

  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ready_q, ready_d;
  logic                 missed_q, missed_d;
  logic                 clr, load;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    scaler_edge_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .in_i   (scaler_i[g]),
      .mask_i (mask_i[g]),
      .clr_i  (clr),
      .load_i (load),
      .cnt_o  (live[g])
    );
  end

  always_comb begin
    period_cap = (period_i == '0) ? PERIOD_WIDTH'(1) : period_i;
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    clr        = 1'b0;
    load       = 1'b0;
    hold_d     = hold_q;
    ready_d    = ready_q;
    missed_d   = missed_q;
    rd_valid_d = rd_if.rd_en_i;
    rd_data_d  = rd_data_q;

    if (rd_if.rd_en_i) begin
      if (int'(rd_if.rd_addr_i) < NCH) begin
        rd_data_d = hold_q[rd_if.rd_addr_i];
      end else begin
        rd_data_d = '0;
      end
    end

    if (rd_if.ack_i) begin
      ready_d  = 1'b0;
      missed_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (enable_i) begin
          state_d = COUNT;
          pcnt_d  = period_cap;
        end
      end
      COUNT: begin
        if (!enable_i) begin
          state_d = IDLE;
          clr     = 1'b1;
        end else begin
          pcnt_d = pcnt_q - 1'b1;
          if (pcnt_q == PERIOD_WIDTH'(1)) begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        load = 1'b1;
        for (int i = 0; i < NCH; i++) begin
          hold_d[i] = live[i];
        end
        // a coincident ack loses to the latch
        ready_d  = 1'b1;
        missed_d = rd_if.ack_i ? missed_q : (missed_q | ready_q);
        pcnt_d   = period_cap;
        state_d  = enable_i ? COUNT : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      hold_q     <= '{default: '0};
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hold_q     <= hold_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ready_q    <= ready_d;
      missed_q   <= missed_d;
    end
  end

  assign gate_o           = (state_q == COUNT);
  assign rd_if.rd_data_o  = rd_data_q;
  assign rd_if.rd_valid_o = rd_valid_q;
  assign rd_if.ready_o    = ready_q;
  assign rd_if.missed_o   = missed_q;

endmodule

// File: doc/anita4_scaler_sequencer.md
Name: anita4_scaler_sequencer

Overview:
- Gated rate-scaler controller for the 12 ANITA4 trigger-map scaler lines (top/mid/bot × LCP/RCP × 2 SURF halves).
- Counts rising edges per channel over a programmable gate period, then latches the counts into a hold bank in one cycle and restarts counting with no dead time.
- Exposes the hold bank to the register interface through an addressed read port with a ready/ack handshake and a sticky missed-readout flag.

Parameters:
- NCH, 12, number of scaler channels. Bit order: {bot_rcp[1:0], bot_lcp[1:0], mid_rcp, mid_lcp, top_rcp, top_lcp}, with bit 0 = top_lcp[0].
- CNT_WIDTH, 16, per-channel counter width; counters saturate.
- PERIOD_WIDTH, 24, width of the gate-period counter.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- scaler_i  in  NCH  scaler levels, already synchronous to clk_i.
- mask_i  in  NCH  1 = channel ignored (its count stays 0).
- enable_i  in  1  run gating.
- period_i  in  PERIOD_WIDTH  gate length in clk_i cycles.
- ack_i  in  1  single-cycle pulse: readout done.
- rd_en_i  in  1  read strobe.
- rd_addr_i  in  4  hold-bank index.
- rd_data_o  out  CNT_WIDTH  hold-bank data.
- rd_valid_o  out  1  rd_data_o is valid.
- ready_o  out  1  new hold bank available.
- missed_o  out  1  sticky: a latch occurred while ready_o was still high.
- gate_o  out  1  high during COUNT.

Behaviour:
- Reset values:
  - All outputs 0.
  - Live counters, hold bank and period counter 0.
  - Edge-detect history register all-ones, so a line high at reset does not count.
  - State IDLE.
- Edge detect: edge[i] = scaler_i[i] & ~prev[i] & ~mask_i[i]. prev updates every cycle in every state.
- States:
  - IDLE: live counters held at 0. When enable_i = 1, capture period_i into pcnt (0 is treated as 1) and go to COUNT.
  - COUNT: gate_o = 1. Each cycle pcnt decrements and live[i] increments on edge[i], saturating at 2^CNT_WIDTH-1. When pcnt reaches 1, go to LATCH.
  - If enable_i falls during COUNT: go to IDLE next cycle, clear live counters, leave the hold bank and ready_o unchanged.
  - LATCH (exactly 1 cycle, gate_o = 0):
    - Copy live to hold, using live values that include any edge from the last COUNT cycle.
    - Reload each live counter to edge[i] (0 or 1), so an edge in the LATCH cycle counts toward the next period.
    - Re-capture period_i into pcnt.
    - Set ready_o. If ready_o was already 1, set missed_o.
    - Next state is COUNT if enable_i = 1, else IDLE.
- Gate timing: period P yields P COUNT cycles plus 1 LATCH cycle. Hold counts cover P+1 edge-sample cycles (the previous LATCH cycle plus P COUNT cycles). The first period after IDLE covers P cycles.
- Read port:
  - Registered, 1-cycle latency: rd_en_i at cycle n gives rd_data_o = hold[rd_addr_i] and rd_valid_o = 1 at n+1.
  - rd_addr_i >= NCH returns 0, still with rd_valid_o = 1.
  - rd_valid_o is low whenever rd_en_i was low the previous cycle. rd_data_o holds its last value.
  - A read in the same cycle as LATCH returns the pre-latch hold value.
- ack_i clears ready_o and missed_o next cycle. If ack_i coincides with LATCH, the LATCH wins: ready_o = 1 and missed_o is unchanged.
- rst_i asserted in any state returns everything to reset values on the next edge. No partial latch occurs.
- Mask changes take effect on the next cycle's edge term. Counts already accumulated are kept.

Decomposition:
- Package anita4_scaler_pkg:
  - State encoding localparams IDLE=2'd0, COUNT=2'd1, LATCH=2'd2.
  - Channel index constants TOP_LCP0…BOT_RCP1.
  - NCH_DEFAULT.
- Sub-module scaler_edge_counter (one per channel, generated), ports clk_i, rst_i, in_i, mask_i, clr_i, load_i, cnt_o:
  - Owns its prev bit, edge detect and saturating counter.
  - clr_i: counter to 0 (IDLE).
  - load_i: counter to this cycle's edge (LATCH).
- Top level owns the FSM, pcnt, hold bank, read mux and flags.

Test Plan:
- period_i=100, enable_i=1, one channel pulsed every 10 cycles (single-cycle high) → hold[ch]=10 after the first latch. ready_o rises 101 cycles after the enable edge. Masked channels read 0.
- CNT_WIDTH=16, toggle scaler_i[3] every cycle for period_i=200000 → hold[3]=65535 (saturated). Other channels 0.
- rd_en_i with addr 5 → next cycle rd_valid_o=1 and rd_data_o=hold[5]. Addr 13 → rd_data_o=0, rd_valid_o=1.
- Two latches with no ack_i → missed_o=1 after the second latch. ack_i → ready_o=0 and missed_o=0. ack_i coincident with a latch → ready_o stays 1.
- Edge placed on the last COUNT cycle counts in the current hold. Edge on the LATCH cycle appears in the next hold (value 1 if it is the only edge).
- enable_i drops mid-COUNT → IDLE, hold bank and ready_o unchanged. rst_i mid-COUNT → all outputs 0. scaler_i held high through reset produces no count.
